fifo_cmd_reader: RTL and testbench

- Drains the 8-bit read port of the clock-domain-crossing byte FIFO and parses length-prefixed command packets.
- Packet format on the wire is op byte, len byte, then len payload bytes.
- Presents the header {op, len} on a valid/ready channel, then streams the payload on a separate valid/ready byte channel with a last flag.
- Sits in the consumer clock domain, directly on the FIFO's rd_en/rd_data/empty side.

---
 rtl/fifo_cmd_reader_pkg.sv | 34 +++
 rtl/fifo_cmd_reader_if.sv | 37 +++
 rtl/fifo_cmd_reader_idle_timer.sv | 43 ++++
 rtl/fifo_cmd_reader.sv | 213 +++++++++++++++++++++
 tb/tb_fifo_cmd_reader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_cmd_reader_pkg.sv
// Shared types and constants for the FIFO command reader.
// Optional feature macro: FIFO_CMD_READER_CHECKSUM_EN adds the CSUM state.
package fifo_cmd_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned LEN_W = 8;

  // Parser states; CSUM exists only when the trailer byte is enabled.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DRAIN   = 3'd4
`ifdef FIFO_CMD_READER_CHECKSUM_EN
    ,
    ST_CSUM    = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERSIZE = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_code_t;

  // Latched packet header.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [LEN_W-1:0] len;
  } cmd_hdr_t;

endpackage

// File: rtl/fifo_cmd_reader_if.sv
// Bundle of the FIFO read side, header channel, payload channel and error
// outputs of the command reader.
//   master : the reader (pops the FIFO, drives header/payload/error)
//   slave  : the environment (FIFO read port and downstream consumers)
interface fifo_cmd_reader_if;
  import fifo_cmd_pkg::*;

  logic [7:0]       fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_en;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [LEN_W-1:0] cmd_len;

  logic             data_valid;
  logic             data_ready;
  logic [7:0]       data;
  logic             data_last;

  logic             err;
  err_code_t        err_code;

  modport master (
    input  fifo_data, fifo_empty, cmd_ready, data_ready,
    output fifo_rd_en, cmd_valid, cmd_op, cmd_len,
           data_valid, data, data_last, err, err_code
  );

  modport slave (
    output fifo_data, fifo_empty, cmd_ready, data_ready,
    input  fifo_rd_en, cmd_valid, cmd_op, cmd_len,
           data_valid, data, data_last, err, err_code
  );

endinterface

// File: rtl/fifo_cmd_reader_idle_timer.sv
// Idle-cycle watchdog for an unfinished packet.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : restart the count (byte popped or not in a timed state)
//   count_i    : one more idle cycle
//   expired_c  : this idle cycle is number TIMEOUT (combinational)
module cmd_idle_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_c
);

  localparam int unsigned RAW_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = (RAW_W > 8) ? RAW_W : 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the idle cycle that would bring the count to TIMEOUT.
  assign expired_c = count_i && (cnt_q == LIMIT);

  // Clear wins; count holds once the limit is hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_cmd_reader.sv
// Parses length-prefixed command packets (op, len, payload) from a
// first-word-fall-through byte FIFO; presents {op,len} on a header channel
// and streams the payload on a byte channel with a last flag.
//   clk, reset_n : FIFO read clock, async active-low reset
//   bus (master) : fifo_data/fifo_empty/fifo_rd_en, cmd_valid/ready/op/len,
//                  data_valid/ready/data/data_last, err/err_code
// fifo_rd_en, data_valid, data and data_last are combinational.
// Macro FIFO_CMD_READER_CHECKSUM_EN: trailing XOR checksum byte per packet.
module fifo_cmd_reader
  import fifo_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_cmd_reader_if.master   bus
);

  // Remaining-byte counter must hold len+1 when the trailer is drained.
  localparam int unsigned REM_W = LEN_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_B = LEN_W'(MAX_LEN);

`ifdef FIFO_CMD_READER_CHECKSUM_EN
  localparam state_t ST_END = ST_CSUM;
`else
  localparam state_t ST_END = ST_IDLE;
`endif

  state_t           state_q, state_d;
  cmd_hdr_t         hdr_q, hdr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  err_code_t        err_code_q, err_code_d;
  logic             run_q;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic pop_c;
  logic dv_c;
  logic last_c;
  logic timed_c;
  logic expired_c;
  logic timer_clear_c;
  logic timer_count_c;

  // States in which a stalled byte stream is watched for timeout.
  always_comb begin
    timed_c = 1'b0;
    case (state_q)
      ST_LEN, ST_PAYLOAD, ST_DRAIN: timed_c = 1'b1;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
      ST_CSUM:                      timed_c = 1'b1;
`endif
      default:                      timed_c = 1'b0;
    endcase
  end

  assign timer_clear_c = pop_c || !timed_c;
  assign timer_count_c = timed_c && bus.fifo_empty;

  cmd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear_i   (timer_clear_c),
    .count_i   (timer_count_c),
    .expired_c (expired_c)
  );

  // Next-state, pop and payload-channel decode.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    pop_c      = 1'b0;
    dv_c       = 1'b0;
    last_c     = 1'b0;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // run_q keeps the pop strobe low until the first edge after reset.
        if (run_q && !bus.fifo_empty) begin
          pop_c    = 1'b1;
          hdr_d.op = bus.fifo_data;
          state_d  = ST_LEN;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
          csum_d   = bus.fifo_data;
`endif
        end
      end

      ST_LEN: begin
        if (!bus.fifo_empty) begin
          pop_c     = 1'b1;
          hdr_d.len = bus.fifo_data;
          rem_d     = REM_W'(bus.fifo_data);
`ifdef FIFO_CMD_READER_CHECKSUM_EN
          csum_d    = csum_q ^ bus.fifo_data;
`endif
          if (bus.fifo_data > MAX_LEN_B) begin
            // Oversize length is never zero since MAX_LEN >= 1.
            err_d      = 1'b1;
            err_code_d = ERR_OVERSIZE;
            state_d    = ST_DRAIN;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
            rem_d      = REM_W'(bus.fifo_data) + REM_W'(1);
`endif
          end else begin
            state_d = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (bus.cmd_ready) begin
          state_d = (hdr_q.len == '0) ? ST_END : ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        dv_c   = !bus.fifo_empty;
        last_c = (rem_q == REM_W'(1));
        if (dv_c && bus.data_ready) begin
          pop_c  = 1'b1;
          rem_d  = rem_q - REM_W'(1);
`ifdef FIFO_CMD_READER_CHECKSUM_EN
          csum_d = csum_q ^ bus.fifo_data;
`endif
          if (last_c) begin
            state_d = ST_END;
          end
        end
      end

      ST_DRAIN: begin
        if (!bus.fifo_empty) begin
          pop_c = 1'b1;
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

`ifdef FIFO_CMD_READER_CHECKSUM_EN
      ST_CSUM: begin
        if (!bus.fifo_empty) begin
          pop_c   = 1'b1;
          state_d = ST_IDLE;
          if (bus.fifo_data != csum_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Expiry implies an empty FIFO, so it never competes with a pop.
    if (expired_c) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      run_q      <= 1'b0;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      run_q      <= 1'b1;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.fifo_rd_en = pop_c;
  assign bus.cmd_valid  = (state_q == ST_HDR);
  assign bus.cmd_op     = hdr_q.op;
  assign bus.cmd_len    = hdr_q.len;
  assign bus.data_valid = dv_c;
  assign bus.data       = bus.fifo_data;
  assign bus.data_last  = last_c;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Directed bench for fifo_cmd_reader: a queue models the FWFT FIFO, a
// per-cycle monitor logs header/payload/error/pop events, and the checks
// compare those logs against hand-computed expectations.
module tb_fifo_cmd_reader;
  import fifo_cmd_pkg::*;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned TIMEOUT = 255;
`ifdef FIFO_CMD_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_cmd_reader_if bus ();

  fifo_cmd_reader #(
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] op;
    logic [7:0] len;
    logic [7:0] base;
    bit         tgl;
    bit         exp_hdr;
    logic [1:0] exp_err;
  } vec_t;

  logic [7:0]  fifo_q[$];
  logic [15:0] hdr_log[$];
  int          hdr_tick[$];
  logic [7:0]  dat_log[$];
  bit          last_log[$];
  int          dat_tick[$];
  logic [1:0]  err_log[$];
  int          err_tick[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_n, pop_first, pop_last, dv_n;
  int rd_bad = 0;
  bit tgl = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic clear_mon();
    hdr_log.delete(); hdr_tick.delete();
    dat_log.delete(); last_log.delete(); dat_tick.delete();
    err_log.delete(); err_tick.delete();
    pop_n = 0; pop_first = -1; pop_last = -1; dv_n = 0;
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic tick();
    bit pop;
    if (tgl) begin
      bus.data_ready = (cyc % 2 == 0);
      bus.cmd_ready  = (cyc % 2 == 0);
    end
    #1;
    pop = bus.fifo_rd_en;
    if (pop) begin
      if (fifo_q.size() == 0) rd_bad++;
      pop_n++;
      if (pop_first < 0) pop_first = cyc;
      pop_last = cyc;
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      hdr_log.push_back({bus.cmd_op, bus.cmd_len});
      hdr_tick.push_back(cyc);
    end
    if (bus.data_valid) dv_n++;
    if (bus.data_valid && bus.data_ready) begin
      dat_log.push_back(bus.data);
      last_log.push_back(bus.data_last);
      dat_tick.push_back(cyc);
    end
    if (bus.err) begin
      err_log.push_back(bus.err_code);
      err_tick.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run until the FIFO is empty and the reader is quiet, bounded.
  task automatic settle();
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < 3000) begin
      tick();
      n++;
      if (fifo_q.size() == 0 && !bus.cmd_valid) idle++;
      else idle = 0;
    end
    chk("settle_bound", (idle >= 4) ? 1 : 0, 1);
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // op, len, payload base+i, plus the XOR trailer when enabled.
  task automatic push_pkt(input logic [7:0] op, input logic [7:0] len,
                          input logic [7:0] base);
    logic [7:0] cs;
    logic [7:0] b;
    cs = op ^ len;
    fifo_q.push_back(op);
    fifo_q.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i);
      cs = cs ^ b;
      fifo_q.push_back(b);
    end
    if (CS != 0) fifo_q.push_back(cs);
    refresh();
  endtask

  // Payload bytes base+i in order with last only on the final one.
  task automatic check_data(input string name, input logic [7:0] base,
                            input int len);
    int bad = 0;
    logic [7:0] b;
    chk({name, "_cnt"}, dat_log.size(), len);
    for (int i = 0; i < dat_log.size() && i < len; i++) begin
      b = base + 8'(i);
      if (dat_log[i] !== b) bad++;
      if (last_log[i] !== (i == len - 1)) bad++;
    end
    chk({name, "_bytes"}, bad, 0);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{op: 8'h05, len: 8'h00, base: 8'h00, tgl: 0, exp_hdr: 1, exp_err: 2'd0};
    vt[1] = '{op: 8'h33, len: 8'h04, base: 8'h40, tgl: 1, exp_hdr: 1, exp_err: 2'd0};
    vt[2] = '{op: 8'h44, len: 8'h50, base: 8'h00, tgl: 0, exp_hdr: 0, exp_err: 2'd1};
    vt[3] = '{op: 8'h21, len: 8'h40, base: 8'h00, tgl: 0, exp_hdr: 1, exp_err: 2'd0};
    vt[4] = '{op: 8'h22, len: 8'h41, base: 8'h00, tgl: 0, exp_hdr: 0, exp_err: 2'd1};
    vt[5] = '{op: 8'h23, len: 8'h01, base: 8'h7F, tgl: 1, exp_hdr: 1, exp_err: 2'd0};
    vt[6] = '{op: 8'h24, len: 8'hFF, base: 8'h00, tgl: 0, exp_hdr: 0, exp_err: 2'd1};
    vt[7] = '{op: 8'h25, len: 8'h02, base: 8'hFE, tgl: 0, exp_hdr: 1, exp_err: 2'd0};

    reset_n = 1'b1;
    bus.cmd_ready  = 1'b1;
    bus.data_ready = 1'b1;
    refresh();
    clear_mon();
    #1 reset_n = 1'b0;
    @(negedge clk);

    // Reset with data waiting: nothing may be popped or issued.
    push_pkt(8'h12, 8'h03, 8'hA0);
    push_pkt(8'h05, 8'h00, 8'h00);
    ticks(3);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_pops", pop_n, 0);
    reset_n = 1'b1;

    // Latency, consecutive payload and back-to-back packets.
    settle();
    chk("a_hdr_cnt", hdr_log.size(), 2);
    if (hdr_log.size() == 2) begin
      chk("a_hdr0", hdr_log[0], 16'h1203);
      chk("a_hdr_latency", hdr_tick[0] - pop_first, 2);
      chk("a_hdr1", hdr_log[1], 16'h0500);
    end
    check_data("a_data", 8'hA0, 3);
    if (dat_tick.size() == 3) begin
      chk("a_data_consec", dat_tick[2] - dat_tick[0], 2);
      chk("a_data_start", dat_tick[0] - hdr_tick[0], 1);
      if (hdr_tick.size() == 2)
        chk("a_b2b", hdr_tick[1] - dat_tick[2], 3 + CS);
    end
    chk("a_err", err_log.size(), 0);

    // Table-driven packets.
    foreach (vt[k]) begin
      int exp_n;
      clear_mon();
      tgl = vt[k].tgl;
      push_pkt(vt[k].op, vt[k].len, vt[k].base);
      settle();
      tgl = 1'b0;
      bus.cmd_ready  = 1'b1;
      bus.data_ready = 1'b1;
      exp_n = vt[k].exp_hdr ? int'(vt[k].len) : 0;
      chk($sformatf("v%0d_hdr_cnt", k), hdr_log.size(), int'(vt[k].exp_hdr));
      if (vt[k].exp_hdr && hdr_log.size() > 0)
        chk($sformatf("v%0d_hdr", k), hdr_log[0], {vt[k].op, vt[k].len});
      check_data($sformatf("v%0d_data", k), vt[k].base, exp_n);
      if (exp_n == 0) chk($sformatf("v%0d_no_dv", k), dv_n, 0);
      chk($sformatf("v%0d_err_cnt", k), err_log.size(), (vt[k].exp_err != 0) ? 1 : 0);
      if (vt[k].exp_err != 0 && err_log.size() > 0)
        chk($sformatf("v%0d_err_code", k), err_log[0], vt[k].exp_err);
      chk($sformatf("v%0d_pops", k), pop_n, 2 + int'(vt[k].len) + CS);
    end

    // Header held for a long time: HDR never times out.
    clear_mon();
    bus.cmd_ready = 1'b0;
    push_pkt(8'h62, 8'h00, 8'h00);
    ticks(300);
    chk("hstall_hdr", hdr_log.size(), 0);
    chk("hstall_err", err_log.size(), 0);
    bus.cmd_ready = 1'b1;
    settle();
    chk("hstall_hdr_after", hdr_log.size(), 1);
    if (hdr_log.size() > 0) chk("hstall_hdr_val", hdr_log[0], 16'h6200);

    // Payload back-pressured with bytes waiting: no timeout.
    clear_mon();
    bus.data_ready = 1'b0;
    push_pkt(8'h61, 8'h02, 8'hC0);
    ticks(300);
    chk("dstall_data", dat_log.size(), 0);
    chk("dstall_err", err_log.size(), 0);
    bus.data_ready = 1'b1;
    settle();
    check_data("dstall_data", 8'hC0, 2);
    chk("dstall_err_after", err_log.size(), 0);

    // Starved payload: timeout after 255 idle cycles, packet abandoned.
    clear_mon();
    push_raw(8'h70); push_raw(8'h03); push_raw(8'hB0);
    ticks(300);
    chk("to_err_cnt", err_log.size(), 1);
    if (err_log.size() > 0) begin
      chk("to_err_code", err_log[0], 2);
      chk("to_err_cycle", err_tick[0] - pop_last, 256);
    end
    chk("to_data_cnt", dat_log.size(), 1);
    if (last_log.size() > 0) chk("to_no_last", last_log[0], 0);
    push_pkt(8'h07, 8'h00, 8'h00);
    settle();
    chk("to_next_hdr_cnt", hdr_log.size(), 2);
    if (hdr_log.size() == 2) chk("to_next_hdr", hdr_log[1], 16'h0700);
    chk("to_next_err", err_log.size(), 1);

    // Reset in the middle of a packet.
    clear_mon();
    bus.data_ready = 1'b0;
    push_raw(8'h50); push_raw(8'h02); push_raw(8'hD0);
    ticks(6);
    reset_n = 1'b0;
    ticks(2);
    chk("mrst_cmd_valid", bus.cmd_valid, 0);
    chk("mrst_data_valid", bus.data_valid, 0);
    chk("mrst_rd_en", bus.fifo_rd_en, 0);
    chk("mrst_err_code", bus.err_code, 0);
    fifo_q.delete();
    refresh();
    reset_n = 1'b1;
    bus.data_ready = 1'b1;
    clear_mon();
    push_pkt(8'h09, 8'h00, 8'h00);
    settle();
    chk("mrst_hdr_cnt", hdr_log.size(), 1);
    if (hdr_log.size() > 0) chk("mrst_hdr", hdr_log[0], 16'h0900);

`ifdef FIFO_CMD_READER_CHECKSUM_EN
    // Trailer checksum: good then bad.
    clear_mon();
    push_raw(8'h01); push_raw(8'h01); push_raw(8'h10); push_raw(8'h10);
    settle();
    chk("cs_good_err", err_log.size(), 0);
    check_data("cs_good_data", 8'h10, 1);
    clear_mon();
    push_raw(8'h01); push_raw(8'h01); push_raw(8'h10); push_raw(8'h11);
    settle();
    chk("cs_bad_err_cnt", err_log.size(), 1);
    if (err_log.size() > 0) begin
      chk("cs_bad_code", err_log[0], 3);
      chk("cs_bad_cycle", err_tick[0] - pop_last, 1);
    end
    check_data("cs_bad_data", 8'h10, 1);
`endif

    chk("rd_en_when_empty", rd_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
